// File: rtl/ic74ls85_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ic74ls85_pkg
// Description : Result encodings and cascade resolution shared by the
//               74LS85-style magnitude comparator.
// Revision    : 1.0 - initial release
// ============================================================================
package ic74ls85_pkg;

    // Result vectors are packed as {lt, eq, gt}
    localparam logic [2:0] c_LT   = 3'b100;
    localparam logic [2:0] c_EQ   = 3'b010;
    localparam logic [2:0] c_GT   = 3'b001;
    localparam logic [2:0] c_NONE = 3'b000;
    localparam logic [2:0] c_LTGT = 3'b101;
    localparam logic [2:0] c_SEED = c_EQ;

    // Datasheet behaviour when A==B; eq_in dominates the other two inputs
    function automatic logic [2:0] resolve_cascade(
        input logic lt_in,
        input logic eq_in,
        input logic gt_in
    );
        logic [2:0] res;
        if (eq_in) begin
            res = c_EQ;
        end else begin
            unique case ({lt_in, gt_in})
                2'b10:   res = c_LT;
                2'b01:   res = c_GT;
                2'b11:   res = c_NONE;
                default: res = c_LTGT;
            endcase
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ic74ls85_core.sv
`default_nettype none
// ============================================================================
// Module      : ic74ls85_core
// Description : Combinational WIDTH-bit unsigned compare with cascade
//               resolution on an exact match.
// Revision    : 1.0 - initial release
// ============================================================================
module ic74ls85_core
    import ic74ls85_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             A_lt_B_in,
    input  logic             A_eq_B_in,
    input  logic             A_gt_B_in,
    output logic [2:0]       result
);

    always_comb begin
        result = resolve_cascade(A_lt_B_in, A_eq_B_in, A_gt_B_in);
        if (A > B) begin
            result = c_GT;
        end else if (A < B) begin
            result = c_LT;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ic74ls85.sv
`default_nettype none
// ============================================================================
// Module      : ic74ls85
// Description : Cascadable magnitude comparator with optional registered
//               one-hot lt/eq/gt outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module ic74ls85
    import ic74ls85_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter bit OUT_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             A_lt_B_in,
    input  logic             A_eq_B_in,
    input  logic             A_gt_B_in,
    output logic             A_lt_B,
    output logic             A_eq_B,
    output logic             A_gt_B
);

    logic [2:0] w_result;
    logic [2:0] w_out;

    ic74ls85_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .A         (A),
        .B         (B),
        .A_lt_B_in (A_lt_B_in),
        .A_eq_B_in (A_eq_B_in),
        .A_gt_B_in (A_gt_B_in),
        .result    (w_result)
    );

    generate
        if (OUT_REG) begin : g_reg
            logic [2:0] r_result;

            // Reset to the equal seed so a downstream stage sees a neutral cascade
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_result <= c_SEED;
                end else begin
                    r_result <= w_result;
                end
            end

            assign w_out = r_result;
        end else begin : g_comb
            logic w_unused;
            assign w_unused = ^{clk, rst_n};
            assign w_out    = w_result;
        end
    endgenerate

    assign {A_lt_B, A_eq_B, A_gt_B} = w_out;

endmodule
`default_nettype wire

// File: tb/tb_ic74ls85.sv
`default_nettype none
// ============================================================================
// Module      : tb_ic74ls85
// Description : Self-checking bench for ic74ls85 (registered 4-bit stage and
//               a two-stage combinational 8-bit chain).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ic74ls85;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       lt_in;
    logic       eq_in;
    logic       gt_in;
    logic       lt;
    logic       eq;
    logic       gt;

    logic [7:0] ch_a;
    logic [7:0] ch_b;
    logic       lo_lt;
    logic       lo_eq;
    logic       lo_gt;
    logic       hi_lt;
    logic       hi_eq;
    logic       hi_gt;

    int n_checks;
    int n_errors;

    // Datasheet tie table indexed by {lt_in, eq_in, gt_in}; entries are {lt, eq, gt}
    logic [2:0] tie_table [8];

    ic74ls85 #(
        .WIDTH   (4),
        .OUT_REG (1'b1)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (a),
        .B         (b),
        .A_lt_B_in (lt_in),
        .A_eq_B_in (eq_in),
        .A_gt_B_in (gt_in),
        .A_lt_B    (lt),
        .A_eq_B    (eq),
        .A_gt_B    (gt)
    );

    ic74ls85 #(
        .WIDTH   (4),
        .OUT_REG (1'b0)
    ) u_lo (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (ch_a[3:0]),
        .B         (ch_b[3:0]),
        .A_lt_B_in (1'b0),
        .A_eq_B_in (1'b1),
        .A_gt_B_in (1'b0),
        .A_lt_B    (lo_lt),
        .A_eq_B    (lo_eq),
        .A_gt_B    (lo_gt)
    );

    ic74ls85 #(
        .WIDTH   (4),
        .OUT_REG (1'b0)
    ) u_hi (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (ch_a[7:4]),
        .B         (ch_b[7:4]),
        .A_lt_B_in (lo_lt),
        .A_eq_B_in (lo_eq),
        .A_gt_B_in (lo_gt),
        .A_lt_B    (hi_lt),
        .A_eq_B    (hi_eq),
        .A_gt_B    (hi_gt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got lt/eq/gt=%b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] model(input int av, input int bv,
                                         input logic l, input logic e, input logic g);
        if (av > bv) return 3'b001;
        if (av < bv) return 3'b100;
        return tie_table[{l, e, g}];
    endfunction

    task automatic apply_reg(input logic [3:0] av, input logic [3:0] bv,
                             input logic l, input logic e, input logic g);
        @(negedge clk);
        a = av; b = bv; lt_in = l; eq_in = e; gt_in = g;
        @(posedge clk);
        #1;
    endtask

    task automatic check_chain(input string tag, input logic [7:0] av, input logic [7:0] bv);
        ch_a = av;
        ch_b = bv;
        #1;
        check(tag, {hi_lt, hi_eq, hi_gt}, model(int'(av), int'(bv), 1'b0, 1'b1, 1'b0));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        tie_table[0] = 3'b101;
        tie_table[1] = 3'b001;
        tie_table[2] = 3'b010;
        tie_table[3] = 3'b010;
        tie_table[4] = 3'b100;
        tie_table[5] = 3'b000;
        tie_table[6] = 3'b010;
        tie_table[7] = 3'b010;

        rst_n = 1'b0;
        a = 4'h0; b = 4'hF; lt_in = 1'b0; eq_in = 1'b0; gt_in = 1'b0;
        ch_a = 8'h00; ch_b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {lt, eq, gt}, 3'b010);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        apply_reg(4'h5, 4'h5, 1'b0, 1'b1, 1'b0);
        check("eq_seed", {lt, eq, gt}, 3'b010);
        @(negedge clk);
        a = 4'hA; b = 4'h3; lt_in = 1'b1; eq_in = 1'b0; gt_in = 1'b0;
        #1;
        check("latency_hold", {lt, eq, gt}, 3'b010);
        @(posedge clk);
        #1;
        check("gt_ignore_cascade", {lt, eq, gt}, 3'b001);
        apply_reg(4'h0, 4'hF, 1'b0, 1'b1, 1'b0);
        check("lt_extreme", {lt, eq, gt}, 3'b100);

        for (int c = 0; c < 8; c++) begin
            logic [2:0] cv;
            cv = 3'(c);
            apply_reg(4'h7, 4'h7, cv[2], cv[1], cv[0]);
            check($sformatf("tie_%b", cv), {lt, eq, gt}, model(7, 7, cv[2], cv[1], cv[0]));
        end

        // Reset mid-stream with A>B applied
        apply_reg(4'h9, 4'h2, 1'b0, 1'b1, 1'b0);
        check("pre_reset_gt", {lt, eq, gt}, 3'b001);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {lt, eq, gt}, 3'b010);
        @(posedge clk);
        #1;
        check("reset_held", {lt, eq, gt}, 3'b010);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_release_gt", {lt, eq, gt}, 3'b001);

        // Exhaustive seeded 4-bit compare, one flag per cycle
        for (int i = 0; i < 256; i++) begin
            logic [7:0] p;
            p = 8'(i);
            apply_reg(p[7:4], p[3:0], 1'b0, 1'b1, 1'b0);
            check($sformatf("exh_%h_%h", p[7:4], p[3:0]), {lt, eq, gt},
                  model(int'(p[7:4]), int'(p[3:0]), 1'b0, 1'b1, 1'b0));
        end

        // Randomised operands and cascade, ties forced often
        for (int i = 0; i < 200; i++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            logic [2:0] rc;
            ra = 4'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? ra : 4'($urandom);
            rc = 3'($urandom);
            apply_reg(ra, rb, rc[2], rc[1], rc[0]);
            check($sformatf("rnd_%h_%h_%b", ra, rb, rc), {lt, eq, gt},
                  model(int'(ra), int'(rb), rc[2], rc[1], rc[0]));
        end

        // Combinational 8-bit chain
        check_chain("ch_56_53", 8'h56, 8'h53);
        check_chain("ch_42_47", 8'h42, 8'h47);
        check_chain("ch_82_7F", 8'h82, 8'h7F);
        check_chain("ch_3F_41", 8'h3F, 8'h41);
        check_chain("ch_AB_AB", 8'hAB, 8'hAB);
        check_chain("ch_00_FF", 8'h00, 8'hFF);
        for (int i = 0; i < 100; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? {ra[7:4], 4'($urandom)} : 8'($urandom);
            check_chain($sformatf("ch_rnd_%h_%h", ra, rb), ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
